sensor_count_transmitter: RTL and testbench
===========================================

// Module: sensor_count_transmitter
// PURPOSE
//  Sensor-side producer of the (next_road, data_in) interface consumed by adaptation_sensor_unit.
//  Accumulates per-road vehicle-arrival pulses in four saturating counters (N,E,S,W).
//  On a controller request, snapshots and clears one road's count, then presents it as data_in.
//  next_road follows one cycle later, so data_in is stable before next_road changes.
// PARAMETERS
//  CNT_W        8   width of each road counter and of data_in; saturates at 2**CNT_W-1
//  HOLD_CYCLES  2   cycles data_valid/next_road are held after presentation; legal range 1..15
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  reset      in   1      synchronous, active-high reset
//  veh_pulse  in   4      1-cycle arrival pulses; bit0=N, bit1=E, bit2=S, bit3=W
//  req        in   1      request to transmit the count of req_road; sampled only in IDLE
//  req_road   in   2      road to transmit (0=N,1=E,2=S,3=W)
//  next_road  out  2      road whose count is on data_in (to consumer next_road)
//  data_in    out  CNT_W  transmitted vehicle count (to consumer data_in)
//  data_valid out  1      high while next_road/data_in form a valid frame
//  busy       out  1      high from request acceptance until return to IDLE
//  overflow   out  4      sticky per-road flag: counter hit saturation since its last send
// BEHAVIOUR
//  Reset: counters=0, next_road=0, data_in=0, data_valid=0, busy=0, overflow=0, FSM=IDLE.
//  Reset mid-frame aborts the frame; all outputs reach reset values after that edge.
//  Counters: +1 per veh_pulse bit; at max they stay at max and set overflow[r].
//  FSM IDLE->LOAD->PRESENT->HOLD->IDLE, all transitions on clock edges.
//   E0 IDLE & req=1: latch road_q<=req_road, busy<=1, ->LOAD. req while busy is ignored.
//   E1 LOAD: data_in<=cnt[road_q]; cnt[road_q]<=veh_pulse[road_q]?1:0; overflow[road_q]<=0; ->PRESENT.
//   E2 PRESENT: next_road<=road_q, data_valid<=1, hold<=HOLD_CYCLES-1, ->HOLD.
//   HOLD: hold==0 -> data_valid<=0, busy<=0, ->IDLE; else hold<=hold-1.
//  data_valid is high for exactly HOLD_CYCLES cycles. next_road and data_in persist after the frame until the next frame.
//  Earliest next acceptance: the first cycle busy==0. Frame period is HOLD_CYCLES+3 cycles.
//  A pulse on the snapshotted road in the LOAD cycle is not lost: the counter restarts at 1.
//  Pulses on other roads count normally in every state.
//  Overflow at the LOAD edge: data_in=max value, overflow cleared.
//  Repeat request for the same road: next_road stays unchanged; consumers qualify frames with data_valid.
// CONFIGURATION
//  TX_PARITY_EN defined: extra output data_parity (1b), even parity of data_in.
//   Registered at the same edge as data_in; reset value 0.
//  TX_PARITY_EN undefined: no data_parity port and no parity logic.
// STRUCTURE
//  traffic_pkg: road codes ROAD_N=0, ROAD_E=1, ROAD_S=2, ROAD_W=3; FSM state encodings; default CNT_W.
//  Sub-module road_counter (clk, reset, inc, clr, count, ovf): saturating counter with clear-plus-inc.
//   The top level instantiates road_counter four times; the FSM and output registers stay in the top level.
// TESTING
//  Reset: 3 N pulses, then req N -> data_in=3; one cycle later next_road=0, data_valid high 2 cycles; N count=0.
//  Saturation: 300 E pulses, req E -> data_in=255, overflow[1]=1 before the LOAD edge and 0 after it.
//  Pulse on S during LOAD of S with count 7 -> data_in=7; next req S -> data_in=1.
//  req asserted while busy -> ignored, no extra frame. Back-to-back reqs -> frames spaced 5 cycles (HOLD_CYCLES=2).
//  reset raised during HOLD -> data_valid=0, busy=0, next_road=0 after the edge; counters cleared.
//  Sequence N,E,S,W with 10,20,30,40 pulses into adaptation_sensor_unit -> each next_road change has settled data_in.
//  With TX_PARITY_EN: data_in=0x07 -> data_parity=1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared road codes, transmitter FSM state encoding and default counter width.
package traffic_pkg;

  // Road codes, also the bit index into veh_pulse/overflow
  localparam logic [1:0] ROAD_N = 2'd0;
  localparam logic [1:0] ROAD_E = 2'd1;
  localparam logic [1:0] ROAD_S = 2'd2;
  localparam logic [1:0] ROAD_W = 2'd3;

  localparam int unsigned DefCntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPresent,
    StHold
  } tx_state_e;

endpackage

// File: rtl/road_counter.sv
// Saturating per-road vehicle counter with a sticky overflow flag.
// A clear that coincides with an arrival restarts the count at 1 so the pulse is kept.
module road_counter
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  // Count arrivals, saturate at max and remember that a pulse was lost
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      count_q <= inc ? CNT_W'(1) : '0;
      ovf_q   <= 1'b0;
    end else if (inc) begin
      if (count_q == CntMax) begin
        ovf_q <= 1'b1;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/sensor_count_transmitter.sv
// Sensor-side producer of the (next_road, data_in) frame interface.
// Counts per-road arrivals; on request snapshots and clears one road, presents the
// count on data_in, then moves next_road one cycle later so data_in is already settled.
// Optional feature: define TX_PARITY_EN to add a registered even-parity output data_parity.
module sensor_count_transmitter
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       veh_pulse,
  input  logic             req,
  input  logic [1:0]       req_road,
  output logic [1:0]       next_road,
  output logic [CNT_W-1:0] data_in,
  output logic             data_valid,
  output logic             busy,
  output logic [3:0]       overflow
`ifdef TX_PARITY_EN
  ,
  output logic             data_parity
`endif
);

  localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES - 1);

  tx_state_e        state_q, state_d;
  logic [1:0]       road_q, road_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic [1:0]       next_road_q, next_road_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [3:0]       hold_q, hold_d;
  logic             load_en;

  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       clr;
  logic [3:0]       ovf;

  for (genvar r = 0; r < 4; r++) begin : g_road
    // Snapshot edge clears only the selected road
    assign clr[r] = load_en & (road_q == 2'(r));

    road_counter #(
      .CNT_W (CNT_W)
    ) u_road_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (veh_pulse[r]),
      .clr   (clr[r]),
      .count (cnt[r]),
      .ovf   (ovf[r])
    );
  end

  // Frame sequencing: accept, snapshot, present, hold, release
  always_comb begin
    state_d     = state_q;
    road_d      = road_q;
    data_d      = data_q;
    next_road_d = next_road_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    hold_d      = hold_q;
    load_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          road_d  = req_road;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        data_d  = cnt[road_q];
        load_en = 1'b1;
        state_d = StPresent;
      end
      StPresent: begin
        next_road_d = road_q;
        valid_d     = 1'b1;
        hold_d      = HoldInit;
        state_d     = StHold;
      end
      StHold: begin
        if (hold_q == 4'd0) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      road_q      <= ROAD_N;
      data_q      <= '0;
      next_road_q <= ROAD_N;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      hold_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      road_q      <= road_d;
      data_q      <= data_d;
      next_road_q <= next_road_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      hold_q      <= hold_d;
    end
  end

`ifdef TX_PARITY_EN
  logic parity_q;

  // Parity tracks data_in edge for edge
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign data_parity = parity_q;
`endif

  assign next_road  = next_road_q;
  assign data_in    = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign overflow   = ovf;

endmodule

// File: tb/tb_sensor_count_transmitter.sv
// Self-checking bench for sensor_count_transmitter against a frame-timeline model.
module tb_sensor_count_transmitter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned HOLD  = 2;
  localparam int          MAXV  = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       veh_pulse;
  logic             req;
  logic [1:0]       req_road;
  logic [1:0]       next_road;
  logic [CNT_W-1:0] data_in;
  logic             data_valid;
  logic             busy;
  logic [3:0]       overflow;
`ifdef TX_PARITY_EN
  logic             data_parity;
`endif

  sensor_count_transmitter #(
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .veh_pulse  (veh_pulse),
    .req        (req),
    .req_road   (req_road),
    .next_road  (next_road),
    .data_in    (data_in),
    .data_valid (data_valid),
    .busy       (busy),
    .overflow   (overflow)
`ifdef TX_PARITY_EN
    ,
    .data_parity(data_parity)
`endif
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: counts as integers, frame as a phase count since acceptance
  int               m_cnt [4];
  bit               m_ovf [4];
  bit               m_busy;
  int               m_phase;
  logic [1:0]       m_road;
  logic [CNT_W-1:0] m_data;
  logic [1:0]       m_nr;
  bit               m_valid;

  function automatic void model_edge(input logic rst, input logic [3:0] p, input logic rq,
                                     input logic [1:0] rr);
    logic [3:0] pv;
    pv = p;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end
      m_busy = 0; m_phase = 0; m_road = 0; m_data = 0; m_nr = 0; m_valid = 0;
      return;
    end
    if (m_busy) m_phase++;
    if (m_busy && m_phase == 1) begin
      m_data = CNT_W'(m_cnt[m_road]);
      m_cnt[m_road] = p[m_road] ? 1 : 0;
      m_ovf[m_road] = 0;
      pv[m_road] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (pv[i]) begin
        if (m_cnt[i] == MAXV) m_ovf[i] = 1;
        else m_cnt[i]++;
      end
    end
    if (m_busy && m_phase == 2) begin
      m_nr = m_road;
      m_valid = 1;
    end
    if (m_busy && m_phase == int'(HOLD) + 2) begin
      m_valid = 0;
      m_busy = 0;
    end else if (!m_busy && rq) begin
      m_busy = 1;
      m_phase = 0;
      m_road = rr;
    end
  endfunction

  function automatic logic [15:0] exp_vec();
    return {m_nr, m_data, m_valid, m_busy, m_ovf[3], m_ovf[2], m_ovf[1], m_ovf[0]};
  endfunction

  function automatic logic [15:0] act_vec();
    return {next_road, data_in, data_valid, busy, overflow};
  endfunction

  // One clock: drive inputs, advance model at the edge, settle 1 time unit after
  task automatic step(input logic rst, input logic [3:0] p, input logic rq, input logic [1:0] rr);
    reset = rst; veh_pulse = p; req = rq; req_road = rr;
    @(posedge clk);
    model_edge(rst, p, rq, rr);
    #1;
    reset = 1'b0; veh_pulse = 4'b0; req = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 4'hf, 1, 2'd3);
    step(1, 4'h0, 0, 2'd0);
    vectors++;
    if (act_vec() !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want %h", act_vec(), 16'h0);
    end
  endtask

  task automatic test_basic();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 4'b0001, 0, 0);
    step(0, 0, 1, 2'd0);
    step(0, 0, 0, 0);
    vectors++;
    if (data_in !== 8'd3 || data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_load data_in=%0d valid=%b want 3/0", data_in, data_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      vectors++;
      if (next_road !== 2'd0 || data_valid !== (i < 2) || data_in !== 8'd3) begin
        miscompares++;
        $display("FAIL basic_frame[%0d] nr=%0d valid=%b data=%0d", i, next_road, data_valid,
                 data_in);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy_end got %b want 0", busy);
    end
    step(0, 0, 1, 2'd0);
    step(0, 0, 0, 0);
    vectors++;
    if (data_in !== 8'd0) begin
      miscompares++;
      $display("FAIL basic_cleared data_in=%0d want 0", data_in);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    step(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 4'b0010, 0, 0);
    vectors++;
    if (overflow[1] !== 1'b1 || act_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL sat_before ovf=%b got %h want %h", overflow, act_vec(), exp_vec());
    end
    step(0, 0, 1, 2'd1);
    step(0, 0, 0, 0);
    vectors++;
    if (data_in !== 8'd255 || overflow[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_load data_in=%0d ovf=%b want 255/0", data_in, overflow[1]);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
  endtask

  task automatic test_load_pulse();
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 4'b0100, 0, 0);
    step(0, 0, 1, 2'd2);
    step(0, 4'b0100, 0, 0);
    vectors++;
    if (data_in !== 8'd7) begin
      miscompares++;
      $display("FAIL loadpulse_first data_in=%0d want 7", data_in);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 2'd2);
    step(0, 0, 0, 0);
    vectors++;
    if (data_in !== 8'd1) begin
      miscompares++;
      $display("FAIL loadpulse_second data_in=%0d want 1", data_in);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
  endtask

  task automatic test_busy_ignore();
    int rises;
    logic prev_v;
    rises = 0;
    prev_v = 0;
    step(1, 0, 0, 0);
    step(0, 0, 1, 2'd0);
    for (int i = 0; i < 12; i++) begin
      step(0, 4'b1000, (i < 3), 2'd3);
      if (data_valid && !prev_v) rises++;
      prev_v = data_valid;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL busy_ignore[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (rises != 1 || next_road !== 2'd0) begin
      miscompares++;
      $display("FAIL busy_ignore_frames rises=%0d nr=%0d want 1/0", rises, next_road);
    end
  endtask

  task automatic test_back_to_back();
    int rises;
    int last;
    logic prev_v;
    rises = 0;
    last = -1;
    prev_v = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      step(0, 4'($urandom), 1, 2'($urandom));
      if (data_valid && !prev_v) begin
        if (last >= 0) begin
          vectors++;
          if (i - last != int'(HOLD) + 3) begin
            miscompares++;
            $display("FAIL b2b_spacing got %0d want %0d", i - last, HOLD + 3);
          end
        end
        last = i;
        rises++;
      end
      prev_v = data_valid;
    end
    vectors++;
    if (rises != 4) begin
      miscompares++;
      $display("FAIL b2b_count got %0d want 4", rises);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 4'hf, 0, 0);
    step(0, 0, 1, 2'd3);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    vectors++;
    if (data_valid !== 1'b1 || next_road !== 2'd3 || data_in !== 8'd5) begin
      miscompares++;
      $display("FAIL midreset_pre valid=%b nr=%0d data=%0d want 1/3/5", data_valid, next_road,
               data_in);
    end
    step(1, 0, 0, 0);
    vectors++;
    if (act_vec() !== 16'h0) begin
      miscompares++;
      $display("FAIL midreset_after got %h want %h", act_vec(), 16'h0);
    end
    step(0, 0, 1, 2'd0);
    step(0, 0, 0, 0);
    vectors++;
    if (data_in !== 8'd0) begin
      miscompares++;
      $display("FAIL midreset_cleared data_in=%0d want 0", data_in);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
  endtask

  task automatic test_sequence();
    logic [CNT_W-1:0] prev_d;
    logic             prev_v;
    step(1, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < (r + 1) * 10; k++) step(0, 4'(1 << r), 0, 0);
    end
    prev_v = 0;
    prev_d = data_in;
    for (int r = 0; r < 4; r++) begin
      step(0, 0, 1, 2'(r));
      for (int i = 0; i < 4; i++) begin
        step(0, 0, 0, 0);
        if (data_valid && !prev_v) begin
          vectors++;
          if (next_road !== 2'(r) || data_in !== prev_d || data_in !== 8'((r + 1) * 10)) begin
            miscompares++;
            $display("FAIL seq_road%0d nr=%0d data=%0d prev=%0d want %0d", r, next_road,
                     data_in, prev_d, (r + 1) * 10);
          end
        end
        prev_v = data_valid;
        prev_d = data_in;
      end
    end
  endtask

  task automatic test_random();
    logic rst;
    step(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      step(rst, 4'($urandom) & 4'($urandom), ($urandom_range(0, 2) == 0), 2'($urandom));
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
`ifdef TX_PARITY_EN
      vectors++;
      if (data_parity !== ^m_data) begin
        miscompares++;
        $display("FAIL random_parity[%0d] got %b want %b", i, data_parity, ^m_data);
      end
`endif
    end
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity();
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 4'b0001, 0, 0);
    step(0, 0, 1, 2'd0);
    step(0, 0, 0, 0);
    vectors++;
    if (data_in !== 8'h07 || data_parity !== 1'b1) begin
      miscompares++;
      $display("FAIL parity data=%h par=%b want 07/1", data_in, data_parity);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
  endtask
`endif

  initial begin
    reset = 1'b1; veh_pulse = 4'b0; req = 1'b0; req_road = 2'd0;
    model_edge(1, 0, 0, 0);
    test_reset();
    test_basic();
    test_saturation();
    test_load_pulse();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_sequence();
    test_random();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
